// File: rtl/aes_pkg.sv
// Shared codes for the AES key-schedule controller: key-length codes,
// Nk/Nr values and the controller FSM encoding.
package aes_pkg;

  typedef enum logic [1:0] {
    KL_128 = 2'b00,
    KL_192 = 2'b01,
    KL_256 = 2'b10,
    KL_BAD = 2'b11
  } key_len_t;

  // kx_nk carries Nk-1, matching what the expansion block expects
  localparam logic [3:0] NK_128 = 4'h3;
  localparam logic [3:0] NK_192 = 4'h5;
  localparam logic [3:0] NK_256 = 4'h7;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_CHECK  = 3'd3,
    ST_READY  = 3'd4,
    ST_STREAM = 3'd5
  } state_t;

  function automatic logic [3:0] nk_of(input logic [1:0] len);
    case (len)
      KL_192:  nk_of = NK_192;
      KL_256:  nk_of = NK_256;
      default: nk_of = NK_128;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] len);
    case (len)
      KL_192:  nr_of = NR_192;
      KL_256:  nr_of = NR_256;
      default: nr_of = NR_128;
    endcase
  endfunction

endpackage

// File: rtl/aes_ks_stream.sv
// Round-key index sequencer: walks 0..Nr (encrypt) or Nr..0 (decrypt)
// under a valid/ready handshake while the controller is streaming.
module aes_ks_stream (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] nr,
  input  logic       launch,
  input  logic       dec,
  input  logic       active,
  input  logic       rk_ready,
  output logic [3:0] idx,
  output logic       rk_valid,
  output logic       rk_last,
  output logic       done
);

  logic [3:0] idx_reg;
  logic       dec_reg;
  logic       step;

  assign idx      = idx_reg;
  assign rk_valid = active;
  assign rk_last  = active && (dec_reg ? (idx_reg == 4'd0) : (idx_reg == nr));
  assign step     = rk_valid && rk_ready;
  assign done     = step && rk_last;

  // The index stops on the final key, so it stays inside 0..Nr
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg <= 4'd0;
      dec_reg <= 1'b0;
    end else if (launch) begin
      dec_reg <= dec;
      idx_reg <= dec ? nr : 4'd0;
    end else if (step && !rk_last) begin
      idx_reg <= dec_reg ? (idx_reg - 4'd1) : (idx_reg + 4'd1);
    end
  end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES key-schedule controller: loads a cipher key, kicks off expansion,
// checks the final round key and streams round keys to the datapath.
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int KX_START_CYCLES = 2,
  parameter int KX_SLACK        = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] key_in,
  input  logic [1:0]   key_len,
  input  logic         key_valid,
  output logic         key_ready,
  output logic [255:0] kx_key,
  output logic [3:0]   kx_nk,
  output logic         kx_start,
  output logic [3:0]   kx_addr,
  input  logic [128:0] kx_ex_key,
  output logic         keys_ready,
  output logic         key_err,
  input  logic         blk_start,
  input  logic         blk_dec,
  output logic         blk_ready,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_idx,
  output logic         rk_last
);

  localparam logic [4:0] START_LAST = 5'(KX_START_CYCLES - 1);

  state_t       state_reg, state_next;
  logic [4:0]   cnt_reg, cnt_next;
  logic [3:0]   nr_reg;
  logic [255:0] key_reg;
  logic [3:0]   nk_reg;
  logic         keys_ready_reg, key_err_reg;
  logic         key_hs, key_bad, blk_hs;
  logic [4:0]   wait_last;
  logic [3:0]   stream_idx;
  logic         stream_done;

  assign key_hs    = key_valid && key_ready;
  assign key_bad   = (key_len == KL_BAD);
  assign blk_hs    = blk_start && blk_ready;
  // Fixed wait covering the expansion, so stale valid bits never reach CHECK
  assign wait_last = {1'b0, nr_reg} + 5'(KX_SLACK - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (key_hs && !key_bad) state_next = ST_START;
      ST_START:  if (cnt_reg == START_LAST) state_next = ST_WAIT;
      ST_WAIT:   if (cnt_reg == wait_last) state_next = ST_CHECK;
      ST_CHECK:  state_next = kx_ex_key[128] ? ST_READY : ST_IDLE;
      ST_READY: begin
        if (key_hs) state_next = key_bad ? ST_IDLE : ST_START;
        else if (blk_hs) state_next = ST_STREAM;
      end
      ST_STREAM: if (stream_done) state_next = ST_READY;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    key_ready = 1'b0;
    blk_ready = 1'b0;
    kx_start  = 1'b0;
    kx_addr   = 4'd0;
    case (state_reg)
      ST_IDLE:  key_ready = 1'b1;
      ST_START: kx_start  = 1'b1;
      ST_WAIT, ST_CHECK: kx_addr = nr_reg;
      ST_READY: begin
        key_ready = 1'b1;
        blk_ready = !key_valid;
      end
      ST_STREAM: kx_addr = stream_idx;
      default: ;
    endcase
  end

  always_comb begin
    cnt_next = cnt_reg;
    if (state_next != state_reg) cnt_next = 5'd0;
    else if (state_reg == ST_START || state_reg == ST_WAIT) cnt_next = cnt_reg + 5'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg        <= 5'd0;
      nr_reg         <= 4'd0;
      key_reg        <= '0;
      nk_reg         <= 4'd0;
      keys_ready_reg <= 1'b0;
      key_err_reg    <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      if (key_hs) begin
        keys_ready_reg <= 1'b0;
        if (key_bad) begin
          key_err_reg <= 1'b1;
        end else begin
          key_err_reg <= 1'b0;
          key_reg     <= key_in;
          nk_reg      <= nk_of(key_len);
          nr_reg      <= nr_of(key_len);
        end
      end else if (state_reg == ST_CHECK) begin
        if (kx_ex_key[128]) keys_ready_reg <= 1'b1;
        else key_err_reg <= 1'b1;
      end
    end
  end

  assign kx_key     = key_reg;
  assign kx_nk      = nk_reg;
  assign keys_ready = keys_ready_reg;
  assign key_err    = key_err_reg;
  assign rk_data    = kx_ex_key[127:0];
  assign rk_idx     = stream_idx;

  aes_ks_stream u_stream (
    .clk      (clk),
    .rst      (rst),
    .nr       (nr_reg),
    .launch   (blk_hs),
    .dec      (blk_dec),
    .active   (state_reg == ST_STREAM),
    .rk_ready (rk_ready),
    .idx      (stream_idx),
    .rk_valid (rk_valid),
    .rk_last  (rk_last),
    .done     (stream_done)
  );

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: behavioural key-expansion model on the kx_*
// side, vector table for key loads and streams, scoreboard on round keys.
module tb_aes_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [255:0] key_in = '0;
  logic [1:0]   key_len = 2'b00;
  logic         key_valid = 1'b0;
  logic         key_ready;
  logic [255:0] kx_key;
  logic [3:0]   kx_nk;
  logic         kx_start;
  logic [3:0]   kx_addr;
  logic [128:0] kx_ex_key;
  logic         keys_ready, key_err;
  logic         blk_start = 1'b0;
  logic         blk_dec = 1'b0;
  logic         blk_ready;
  logic         rk_valid;
  logic         rk_ready = 1'b1;
  logic [127:0] rk_data;
  logic [3:0]   rk_idx;
  logic         rk_last;

  always #5 clk = ~clk;

  aes_key_sched_ctrl #(.KX_START_CYCLES(2), .KX_SLACK(4)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_len(key_len), .key_valid(key_valid),
    .key_ready(key_ready), .kx_key(kx_key), .kx_nk(kx_nk), .kx_start(kx_start),
    .kx_addr(kx_addr), .kx_ex_key(kx_ex_key), .keys_ready(keys_ready), .key_err(key_err),
    .blk_start(blk_start), .blk_dec(blk_dec), .blk_ready(blk_ready), .rk_valid(rk_valid),
    .rk_ready(rk_ready), .rk_data(rk_data), .rk_idx(rk_idx), .rk_last(rk_last)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- key expansion model ----------------
  logic [7:0]   sbox [0:255];
  logic [127:0] rk_mem [0:15];
  logic         rk_vld [0:15];
  logic         exp_fail = 1'b0;
  logic         kx_start_d = 1'b0;
  int           vld_timer = 0;

  assign kx_ex_key = {rk_vld[kx_addr], rk_mem[kx_addr]};

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int b = 0; b < 256; b++) begin
      inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (gmul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]};
      sbox[b] = s ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  task automatic expand(input logic [255:0] key, input logic [3:0] nkc);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rcon;
    int nk, nr;
    nk = int'(nkc) + 1;
    nr = nk + 6;
    rcon = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[32*(nk-1-i) +: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subword({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subword(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rk_mem[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  // Expansion starts on the kx_start rising edge; valid bits appear later
  always @(negedge clk) begin
    if (kx_start && !kx_start_d) begin
      for (int r = 0; r < 16; r++) rk_vld[r] = 1'b0;
      expand(kx_key, kx_nk);
      vld_timer = 6;
    end else if (vld_timer > 0) begin
      if (vld_timer == 1 && !exp_fail)
        for (int r = 0; r < 16; r++) rk_vld[r] = 1'b1;
      vld_timer--;
    end
    kx_start_d = kx_start;
  end

  // ---------------- scoreboard / monitor ----------------
  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] data;
    logic         last;
  } rk_exp_t;

  rk_exp_t      sb_q[$];
  int           hs_cnt = 0;
  int           kx_start_cnt = 0;
  int           rkv_cnt = 0;
  logic         hold_pending = 1'b0;
  logic [127:0] hold_data;
  logic [3:0]   hold_idx;
  logic [127:0] last_data = '0;

  always @(negedge clk) begin
    rk_exp_t e;
    if (kx_start) kx_start_cnt++;
    if (rk_valid) rkv_cnt++;
    if (rst) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending && rk_valid) begin
        chk("stall_data", rk_data, hold_data);
        chk("stall_idx", rk_idx, hold_idx);
      end
      hold_pending = rk_valid && !rk_ready;
      hold_data = rk_data;
      hold_idx = rk_idx;
      if (rk_valid && rk_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rk: got idx %0d, expected no round key", rk_idx);
        end else begin
          e = sb_q.pop_front();
          chk("rk_idx", rk_idx, e.idx);
          chk("rk_data", rk_data, e.data);
          chk("rk_last", rk_last, e.last);
          hs_cnt++;
          if (rk_last) last_data = rk_data;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic load_key(input logic [1:0] len, input logic [255:0] key);
    @(posedge clk); #1;
    key_len = len; key_in = key; key_valid = 1'b1;
    @(negedge clk);
    chk("key_ready", key_ready, 1);
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  task automatic wait_ready(output int lat);
    lat = 0;
    while (!keys_ready && !key_err && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic push_stream(input logic dec, input int nr);
    int idx;
    for (int k = 0; k <= nr; k++) begin
      idx = dec ? nr - k : k;
      sb_q.push_back('{idx: 4'(idx), data: rk_mem[idx], last: (k == nr)});
    end
  endtask

  task automatic run_stream(input logic dec, input int nr, input logic stall);
    int base, n;
    push_stream(dec, nr);
    blk_dec = dec; blk_start = 1'b1;
    @(negedge clk);
    chk("blk_ready", blk_ready, 1);
    @(posedge clk); #1;
    blk_start = 1'b0;
    base = hs_cnt; n = 0;
    while (hs_cnt - base < nr + 1 && n < 400) begin
      rk_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      n++;
    end
    chk("rk_count", hs_cnt - base, nr + 1);
    if (!stall) chk("stream_cycles", n, nr + 1);
    chk("rk_valid_after", rk_valid, 0);
    chk("back_to_ready", blk_ready, 1);
    rk_ready = 1'b1;
  endtask

  typedef struct {
    logic [1:0]   len;
    logic [255:0] key;
    logic         dec;
    logic         stall;
    logic [3:0]   exp_nk;
    int           exp_nr;
    int           exp_lat;
    logic         exp_err;
    logic [127:0] exp_last;
  } vec_t;

  vec_t vecs [5];

  localparam logic [255:0] K128 = 256'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] K192 = 256'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] K128B = 256'h2b7e151628aed2a6abf7158809cf4f3c;

  initial begin
    int lat, base, n;
    vecs[0] = '{2'b00, K128, 1'b0, 1'b0, 4'h3, 10, 17, 1'b0, 128'h13111d7fe3944a17f307a78b4d2b30c5};
    vecs[1] = '{2'b01, K192, 1'b1, 1'b0, 4'h5, 12, 19, 1'b0, 128'h000102030405060708090a0b0c0d0e0f};
    vecs[2] = '{2'b10, K256, 1'b1, 1'b1, 4'h7, 14, 21, 1'b0, 128'h000102030405060708090a0b0c0d0e0f};
    vecs[3] = '{2'b00, K128B, 1'b1, 1'b1, 4'h3, 10, 17, 1'b0, 128'h2b7e151628aed2a6abf7158809cf4f3c};
    vecs[4] = '{2'b11, 256'hdeadbeef, 1'b0, 1'b0, 4'h0, 0, 0, 1'b1, 128'h0};

    build_sbox();
    for (int r = 0; r < 16; r++) begin
      rk_vld[r] = 1'b0;
      rk_mem[r] = '0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_flags", {key_ready, kx_start, keys_ready, key_err, rk_valid, rk_last, blk_ready}, 7'b1000000);
    chk("rst_kx_addr", kx_addr, 0);
    chk("rst_kx_key", kx_key, 0);
    chk("rst_kx_nk", kx_nk, 0);
    rst = 1'b0;

    // Vector table: load, expansion wait, stream
    for (int v = 0; v < 5; v++) begin
      kx_start_cnt = 0;
      load_key(vecs[v].len, vecs[v].key);
      if (vecs[v].exp_err) begin
        repeat (25) @(posedge clk);
        #1;
        chk("bad_len_flags", {key_err, keys_ready, key_ready}, 3'b101);
        chk("bad_len_no_start", kx_start_cnt, 0);
      end else begin
        chk("kx_nk", kx_nk, vecs[v].exp_nk);
        chk("kx_key", kx_key, vecs[v].key);
        chk("key_err_clr", key_err, 0);
        wait_ready(lat);
        chk("ready_lat", lat, vecs[v].exp_lat);
        chk("kx_start_len", kx_start_cnt, 2);
        chk("keys_ready", {keys_ready, key_err}, 2'b10);
        run_stream(vecs[v].dec, vecs[v].exp_nr, vecs[v].stall);
        chk("last_key", last_data, vecs[v].exp_last);
      end
    end

    // Final-key valid check fails: error, back to IDLE
    exp_fail = 1'b1;
    load_key(2'b00, K128);
    chk("fail_err_clr", key_err, 0);
    wait_ready(lat);
    chk("fail_lat", lat, 17);
    chk("fail_flags", {key_err, keys_ready, key_ready}, 3'b101);
    exp_fail = 1'b0;

    // Key load wins over blk_start in READY
    load_key(2'b00, K128);
    wait_ready(lat);
    chk("pre_coll_ready", keys_ready, 1);
    @(posedge clk); #1;
    key_valid = 1'b1; key_len = 2'b00; key_in = K128B; blk_start = 1'b1; blk_dec = 1'b0;
    @(negedge clk);
    chk("coll_blk_ready", blk_ready, 0);
    @(posedge clk); #1;
    key_valid = 1'b0; blk_start = 1'b0;
    rkv_cnt = 0;
    chk("coll_flags", {keys_ready, key_ready}, 2'b00);
    chk("coll_kx_key", kx_key, K128B);
    wait_ready(lat);
    chk("coll_lat", lat, 17);
    chk("coll_no_rk_valid", rkv_cnt, 0);

    // Reset while streaming at idx 5
    push_stream(1'b0, 10);
    blk_dec = 1'b0; blk_start = 1'b1;
    @(posedge clk); #1;
    blk_start = 1'b0;
    base = hs_cnt; n = 0;
    while (!(rk_valid && rk_idx == 4'd5) && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rst_reached_idx", rk_idx, 5);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_flags", {rk_valid, keys_ready, key_ready, blk_ready, kx_start}, 5'b00100);
    chk("midrst_kx_addr", kx_addr, 0);
    chk("midrst_hs", hs_cnt - base, 5);
    rst = 1'b0;
    sb_q.delete();
    @(posedge clk); #1;
    chk("post_rst_idle", {key_ready, keys_ready, rk_valid}, 3'b100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_key_sched_ctrl.md
Name: aes_key_sched_ctrl

Overview:
Controller that sits between the host/key-load interface, the key expansion block and the AES round datapath. It accepts a cipher key with a length code and pulses the expansion start. It waits out the expansion and checks the valid bit of the final round key. It then streams round keys to the round datapath on request: forward order for encryption, reverse order for decryption.

Parameters:
KX_START_CYCLES, 2, cycles kx_start is held high (expansion start is edge-latched, FSM-sampled)
KX_SLACK, 4, extra cycles waited beyond Nr before final-key valid check

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
key_in  in  256  cipher key, lower bits first (128-bit key in [127:0], 192 in [191:0])
key_len  in  2  00=128, 01=192, 10=256, 11=illegal
key_valid  in  1  key load request
key_ready  out  1  key load accepted when key_valid&&key_ready
kx_key  out  256  registered key to expansion
kx_nk  out  4  3/5/7 for 128/192/256
kx_start  out  1  expansion start
kx_addr  out  4  round-key read address
kx_ex_key  in  129  {valid, round key} read data (combinational read)
keys_ready  out  1  expanded key set valid
key_err  out  1  sticky: illegal length or expansion check failed
blk_start  in  1  request round-key stream
blk_dec  in  1  sampled with blk_start: 1=reverse order
blk_ready  out  1  blk_start accepted when blk_start&&blk_ready
rk_valid  out  1  round key valid
rk_ready  in  1  consumer accepts round key
rk_data  out  128  round key
rk_idx  out  4  round index of rk_data
rk_last  out  1  final key of stream

Behaviour:
- Reset: state IDLE. key_ready=1, kx_start=0, keys_ready=0, key_err=0, rk_valid=0, rk_last=0, blk_ready=0, kx_addr=0, kx_key=0, kx_nk=0. Reset mid-operation abandons any expansion or stream immediately.
- States: IDLE, START, WAIT, CHECK, READY, STREAM.
- key_ready=1 in IDLE and READY only.
- Key handshake:
  - Register key_in, kx_nk, Nr (10/12/14); clear keys_ready and key_err; go to START.
  - If key_len=11: set key_err, keys_ready=0, stay/return IDLE, no kx_start.
- START: kx_start=1 for exactly KX_START_CYCLES cycles, then WAIT. kx_key and kx_nk are stable from START entry until the next key load.
- WAIT: counter runs Nr+KX_SLACK cycles; kx_addr=Nr throughout; then CHECK.
- CHECK (1 cycle):
  - If kx_ex_key[128]=1: keys_ready=1, go READY.
  - Else: key_err=1, go IDLE.
  - Stale valid bits from a prior key are masked by the fixed wait; this is documented as an integration requirement.
- READY: blk_ready = !key_valid. A key load has priority over blk_start in the same cycle. On blk_start accept: latch blk_dec; idx=0 (enc) or Nr (dec); go STREAM.
- STREAM:
  - kx_addr=idx; rk_data=kx_ex_key[127:0]; rk_idx=idx; rk_valid=1.
  - rk_last=1 when idx=Nr (enc) or idx=0 (dec).
  - On rk_valid&&rk_ready: idx steps ±1. On the last key: go READY, rk_valid=0 next cycle.
  - rk_data holds stable while rk_valid&&!rk_ready.
  - key_valid is ignored (key_ready=0); blk_start is ignored.
- Throughput: one key per cycle when rk_ready is held high. Stream length is Nr+1 keys. First rk_valid is one cycle after the blk_start accept.
- Idx arithmetic: 4-bit, never wraps (bounded 0..Nr).

Decomposition:
- Shared package aes_pkg: key_len codes, NK_128/192/256 = 4'h3/4'h5/4'h7, NR_128/192/256 = 10/12/14, FSM state encoding.
- Optional sub-module aes_ks_stream: the READY/STREAM index sequencer with handshake.
- Top-level FSM holds load/start/wait/check.

Test Plan:
- FIPS-197 128-bit key 000102..0f, enc stream, rk_ready=1 -> 11 keys idx 0..10 in 11 consecutive cycles; idx10 = 13111d7fe3944a17f307a78b4d2b30c5 with rk_last=1.
- 256-bit key, dec stream with random rk_ready stalls -> 15 keys idx 14..0; rk_data stable during stalls; rk_last on idx0.
- 192-bit key load -> kx_nk=5, kx_start high 2 cycles, keys_ready after 2+16+1 cycles; stream length 13.
- key_len=11 -> key_err=1, kx_start never asserts, keys_ready=0.
- key_valid and blk_start same cycle in READY -> key load taken, blk_ready=0, keys_ready drops, no rk_valid.
- rst asserted mid-STREAM at idx 5 -> next cycle rk_valid=0, keys_ready=0, key_ready=1, state IDLE.
